// File: rtl/result_drain_pkg.sv
// Shared constants and types for the result SRAM drain path and the
// companion input-loader block.
package result_drain_pkg;

  localparam int unsigned RD_ADDRESSSIZE = 10;
  localparam int unsigned RD_MATRIX_SIZE = 64;
  localparam int unsigned RD_PSUM_BW     = 24;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned BUF_CNT_W = $clog2(BUF_DEPTH + 1);

  function automatic int unsigned row_width(input int unsigned n, input int unsigned bw);
    return n * bw;
  endfunction

  localparam int unsigned RD_ROW_W = row_width(RD_MATRIX_SIZE, RD_PSUM_BW);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } drain_state_e;

endpackage

// File: rtl/result_skid_buf.sv
// Small FIFO of {row_idx, data} entries with occupancy count; push and pop
// may happen in the same cycle.
module result_skid_buf
  import result_drain_pkg::*;
#(
  parameter int unsigned DATA_W = RD_ROW_W,
  parameter int unsigned IDX_W  = RD_ADDRESSSIZE
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_push,
  input  logic [IDX_W-1:0]     i_idx,
  input  logic [DATA_W-1:0]    i_data,
  input  logic                 i_pop,
  output logic [IDX_W-1:0]     o_idx,
  output logic [DATA_W-1:0]    o_data,
  output logic [BUF_CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [DATA_W-1:0]    r_data [BUF_DEPTH];
  logic [IDX_W-1:0]     r_idx  [BUF_DEPTH];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [BUF_CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != BUF_CNT_W'(BUF_DEPTH)) || w_do_pop);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= ptr_next(r_wptr);
      if (w_do_pop)  r_rptr <= ptr_next(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; o_count gates its use.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_data[r_wptr] <= i_data;
      r_idx[r_wptr]  <= i_idx;
    end
  end

  assign o_data  = r_data[r_rptr];
  assign o_idx   = r_idx[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/result_drain.sv
// Drains MATRIX_SIZE result rows from the result SRAM after each job-complete
// edge and streams them on a valid/ready interface with 2 entries of credit.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int unsigned ADDRESSSIZE    = RD_ADDRESSSIZE,
  parameter int unsigned MATRIX_SIZE    = RD_MATRIX_SIZE,
  parameter int unsigned PARTIAL_SUM_BW = RD_PSUM_BW,
  parameter int unsigned ROW_W          = row_width(MATRIX_SIZE, PARTIAL_SUM_BW)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   end_,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  output logic                   sram_rd_en,
  output logic [ADDRESSSIZE-1:0] sram_rd_addr,
  input  logic [ROW_W-1:0]       sram_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ROW_W-1:0]       out_data,
  output logic [ADDRESSSIZE-1:0] out_row_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int unsigned CNT_W = $clog2(MATRIX_SIZE + 1);

  drain_state_e           r_state;
  logic                   r_end_d;
  logic                   r_inflight;
  logic                   r_overrun;
  logic [ADDRESSSIZE-1:0] r_base;
  logic [ADDRESSSIZE-1:0] r_rd_idx;
  logic [CNT_W-1:0]       r_issue_cnt;

  logic                   w_start;
  logic                   w_accept;
  logic                   w_issue_left;
  logic                   w_credit;
  logic                   w_rd_en;
  logic                   w_done;
  logic                   w_buf_nonempty;
  logic                   w_bypass;
  logic                   w_push;
  logic                   w_pop;
  logic [BUF_CNT_W-1:0]   w_count;
  logic [ADDRESSSIZE-1:0] w_head_idx;
  logic [ROW_W-1:0]       w_head_data;

  assign w_start        = end_ && !r_end_d;
  assign w_issue_left   = r_issue_cnt < CNT_W'(MATRIX_SIZE);
  assign w_credit       = (32'(w_count) + 32'(r_inflight)) < BUF_DEPTH;
  assign w_rd_en        = (r_state == ST_DRAIN) && w_issue_left && w_credit;
  assign w_done         = (r_state == ST_FLUSH) && (w_count == '0) && !r_inflight;
  assign w_accept       = w_start && ((r_state == ST_IDLE) || w_done);
  assign w_buf_nonempty = (w_count != '0);

  // Returning read data is presented directly when the buffer is empty and
  // only parked in the buffer if the consumer does not take it that cycle.
  assign w_bypass = !w_buf_nonempty && r_inflight;
  assign w_pop    = w_buf_nonempty && out_ready;
  assign w_push   = r_inflight && !(w_bypass && out_ready);

  result_skid_buf #(
    .DATA_W (ROW_W),
    .IDX_W  (ADDRESSSIZE)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_idx   (r_rd_idx),
    .i_data  (sram_rd_data),
    .i_pop   (w_pop),
    .o_idx   (w_head_idx),
    .o_data  (w_head_data),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_end_d     <= 1'b0;
      r_inflight  <= 1'b0;
      r_overrun   <= 1'b0;
      r_base      <= '0;
      r_rd_idx    <= '0;
      r_issue_cnt <= '0;
    end else begin
      r_end_d    <= end_;
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_rd_idx    <= ADDRESSSIZE'(r_issue_cnt);
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end
      if (w_start && busy) r_overrun <= 1'b1;
      if (w_accept) begin
        r_base      <= base_addr;
        r_issue_cnt <= '0;
        r_state     <= ST_DRAIN;
      end else begin
        case (r_state)
          ST_IDLE:  r_state <= ST_IDLE;
          ST_DRAIN: if (!w_issue_left) r_state <= ST_FLUSH;
          ST_FLUSH: if (w_done) r_state <= ST_IDLE;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign sram_rd_en   = w_rd_en;
  assign sram_rd_addr = r_base + ADDRESSSIZE'(r_issue_cnt);

  assign out_valid   = w_buf_nonempty || r_inflight;
  assign out_data    = w_buf_nonempty ? w_head_data : (r_inflight ? sram_rd_data : '0);
  assign out_row_idx = w_buf_nonempty ? w_head_idx : (r_inflight ? r_rd_idx : '0);
  assign out_last    = (out_row_idx == ADDRESSSIZE'(MATRIX_SIZE - 1));

  assign busy    = (r_state != ST_IDLE) && !w_done;
  assign done    = w_done;
  assign overrun = r_overrun;

endmodule
